// File: rtl/commit_reclaim_if.sv
// Commit / free-list / recovery signal bundle between the ROB-side
// environment and the commit_reclaim block.
// slave  : the commit_reclaim block itself.
// master : the surrounding ROB, free list and map table.
interface commit_reclaim_if #(
    parameter int unsigned PREG_W = 7
);
    // ROB commit handshake
    logic              commit_valid;
    logic              commit_ready;
    logic              commit_has_rd;
    logic [4:0]        commit_rd;
    logic [PREG_W-1:0] commit_pd_new;
    logic [PREG_W-1:0] commit_pd_old;

    // Freed-register stream toward the free list
    logic              free_valid;
    logic [PREG_W-1:0] free_preg;
    logic              free_ready;

    // Mispredict recovery stream toward the rename map table
    logic              mispredict;
    logic              recover_busy;
    logic              recover_valid;
    logic [4:0]        recover_areg;
    logic [PREG_W-1:0] recover_preg;

    modport slave (
        input  commit_valid, commit_has_rd, commit_rd, commit_pd_new, commit_pd_old,
        output commit_ready,
        output free_valid, free_preg,
        input  free_ready,
        input  mispredict,
        output recover_busy, recover_valid, recover_areg, recover_preg
    );

    modport master (
        output commit_valid, commit_has_rd, commit_rd, commit_pd_new, commit_pd_old,
        input  commit_ready,
        input  free_valid, free_preg,
        output free_ready,
        output mispredict,
        input  recover_busy, recover_valid, recover_areg, recover_preg
    );
endinterface

// File: rtl/commit_reclaim.sv
// Retirement-side partner of the rename stage: keeps the committed
// architectural map, returns released physical registers to the free list
// through a small FIFO, and streams the committed map back to the rename
// map table after a mispredict.
module commit_reclaim #(
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned AREG_N   = 32,
    parameter int unsigned FQ_DEPTH = 4
) (
    input logic              clk,
    input logic              reset,
    commit_reclaim_if.slave  bus
);
    localparam int unsigned AREG_W = $clog2(AREG_N);
    localparam int unsigned PTR_W  = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        IDLE,
        RECOVER
    } state_t;

    state_t            state_q, state_d;
    logic [AREG_W-1:0] idx_q, idx_d;
    logic              run_q, run_d;

    logic [PREG_W-1:0] arch_map_q [AREG_N];
    logic [PREG_W-1:0] arch_map_d [AREG_N];

    logic [PREG_W-1:0] fifo_q [FQ_DEPTH];
    logic [PREG_W-1:0] fifo_d [FQ_DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic accept;
    logic map_wr;
    logic push;
    logic pop;

    // Commit and free-side handshakes; run_q keeps commit_ready low while
    // in reset and until the first edge after release.
    always_comb begin
        bus.commit_ready = run_q && (state_q == IDLE) && !bus.mispredict
                           && (count_q < CNT_W'(FQ_DEPTH));
        accept           = bus.commit_valid && bus.commit_ready;
        map_wr           = accept && bus.commit_has_rd && (bus.commit_rd != '0);
        push             = map_wr && (bus.commit_pd_old != '0);
        bus.free_valid   = (count_q != '0);
        bus.free_preg    = fifo_q[head_q];
        pop              = bus.free_valid && bus.free_ready;
        run_d            = 1'b1;
    end

    // Committed map update on an accepted register-writing commit.
    always_comb begin
        arch_map_d = arch_map_q;
        if (map_wr) begin
            arch_map_d[bus.commit_rd] = bus.commit_pd_new;
        end
    end

    // Freed-register FIFO: push from commit, pop toward the free list.
    always_comb begin
        fifo_d  = fifo_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            fifo_d[tail_q] = bus.commit_pd_old;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Recovery FSM: next state, walk index and restore outputs.
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        bus.recover_busy  = 1'b0;
        bus.recover_valid = 1'b0;
        bus.recover_areg  = '0;
        bus.recover_preg  = '0;
        case (state_q)
            IDLE: begin
                if (bus.mispredict && run_q) begin
                    state_d = RECOVER;
                    idx_d   = '0;
                end
            end
            RECOVER: begin
                bus.recover_busy  = 1'b1;
                bus.recover_valid = 1'b1;
                bus.recover_areg  = 5'(idx_q);
                bus.recover_preg  = arch_map_q[idx_q];
                if (idx_q == AREG_W'(AREG_N - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // State registers; reset restores the identity map and empties the FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            run_q   <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < AREG_N; i++) begin
                arch_map_q[i] <= PREG_W'(i);
            end
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            arch_map_q <= arch_map_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: doc/commit_reclaim.md
Name: commit_reclaim

Overview:
- Retirement-side partner of the rename stage.
- Accepts committed instructions from the ROB and updates the architectural (committed) register map.
- Returns each retired instruction's old physical register (pd_old) to the free list through a small buffering FIFO.
- On a mispredict, streams the full committed map back to the rename map table so speculative mappings are discarded.

Parameters:
- PREG_W, 7, physical register index width; preg 0 is reserved as "none" and is never reclaimed.
- AREG_N, 32, number of architectural registers; index width is 5.
- FQ_DEPTH, 4, depth of the freed-register FIFO; must be a power of 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- commit_valid  in  1  ROB presents a retiring instruction.
- commit_ready  out  1  block accepts the commit this cycle.
- commit_has_rd  in  1  retiring instruction writes a destination register (0 for stores and branches).
- commit_rd  in  5  architectural destination register.
- commit_pd_new  in  PREG_W  physical register now holding the committed value.
- commit_pd_old  in  PREG_W  previous mapping of rd; released to the free list.
- free_valid  out  1  freed preg is available for the free list.
- free_preg  out  PREG_W  freed physical register (FIFO head).
- free_ready  in  1  free list consumes free_preg.
- mispredict  in  1  single-cycle pulse from the ROB.
- recover_busy  out  1  high while the map restore is in progress.
- recover_valid  out  1  restore write strobe to the map table.
- recover_areg  out  5  architectural index being restored.
- recover_preg  out  PREG_W  committed mapping for recover_areg.

Behaviour:
- Reset (asynchronous, reset==0):
  - arch_map[i] = i for all i.
  - FIFO emptied (head, tail, count = 0); state = IDLE; restore index = 0.
  - All outputs 0 (commit_ready goes high on the first cycle after reset release).
- commit_ready is combinational: (state==IDLE) && !mispredict && (count<FQ_DEPTH). It does not depend on free_ready.
- Commit accept is commit_valid && commit_ready. On accept:
  - If commit_has_rd && commit_rd!=0: arch_map[commit_rd] <= commit_pd_new next edge.
  - In that same case, pd_old is pushed to the FIFO only if commit_pd_old!=0.
  - If commit_has_rd==0 or commit_rd==0: no map update and no push.
- Free side:
  - free_valid = (count!=0); free_preg = FIFO head, registered storage with zero-latency output.
  - Pop occurs when free_valid && free_ready.
  - Push and pop in the same cycle leave count unchanged; head and tail wrap modulo FQ_DEPTH.
  - A push into a full FIFO cannot occur, because commit_ready is low when full.
- FIFO drains in every state, including RECOVER. Freed pregs are committed state and stay valid across a mispredict.
- FSM states: IDLE, RECOVER.
  - IDLE -> RECOVER when mispredict==1. Restore index <= 0. A commit in that cycle is not accepted.
  - RECOVER: recover_busy=1, recover_valid=1, recover_areg=idx, recover_preg=arch_map[idx]. idx increments by 1 each cycle.
  - RECOVER -> IDLE after the cycle with idx==AREG_N-1 (32 restore cycles total).
  - mispredict in RECOVER is ignored; the walk neither restarts nor extends.
  - commit_ready stays low from the mispredict cycle through the last restore cycle (33 cycles).
- In IDLE: recover_valid=0, recover_busy=0, recover_areg=0, recover_preg=0.
- arch_map is not written during RECOVER, since no commits are accepted.
- Reset asserted mid-RECOVER or with a non-empty FIFO: immediate return to the reset state; the partial restore and pending frees are discarded.

Test Plan:
- Reset release, then commit (has_rd=1, rd=5, pd_new=40, pd_old=5) with free_ready=1:
  - next cycle free_valid=1, free_preg=5; popped that cycle, then free_valid=0.
  - arch_map[5]=40.
- Commit a store (has_rd=0) and a write to rd=0, with pd_old=12:
  - free_valid stays 0; arch_map unchanged.
- free_ready=0, five back-to-back commits with pd_old=20,21,22,23,24:
  - first four accepted; commit_ready=0 on the fifth while count=4.
  - after free_ready=1, free_preg order is 20,21,22,23; the fifth is accepted once count<4.
- Simultaneous push and pop at count=2, with a wrap of the tail pointer:
  - count stays 2; FIFO order is preserved.
- After a commit rd=3 -> pd 50, pulse mispredict:
  - commit_ready=0 that cycle; then 32 cycles of recover_valid=1 with recover_areg 0..31.
  - the cycle with areg=3 shows recover_preg=50; all other aregs show preg=areg.
  - commit_ready=1 on the 34th cycle counting the mispredict cycle as 1.
  - a second mispredict mid-walk does not lengthen it.
- Assert reset while in RECOVER at idx=10 with FIFO count=3:
  - recover_valid=0, free_valid=0, commit_ready=0 immediately.
  - after release: identity map, commit_ready=1.
